// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM arbiter: bus types, length codes,
// sequencer states and the length-code decoder.
package mem_arbiter_pkg;

  typedef logic [31:0] RegBus;
  typedef logic [31:0] InstAddrBus;
  typedef logic [7:0]  RamDataBus;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_RD  = 2'b01,
    MEM_RD = 2'b10,
    MEM_WR = 2'b11
  } state_e;

  // The unused code 2'b10 falls through to a full word.
  function automatic logic [2:0] lenToBytes(input logic [1:0] len);
    case (len)
      LenByte: lenToBytes = 3'd1;
      LenHalf: lenToBytes = 3'd2;
      default: lenToBytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising 32-bit fetches and 1/2/4-byte little-endian loads and stores.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_cancel_i,
  output logic                  if_done_o,
  output RegBus                 if_data_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  RegBus                 mem_wdata_i,
  output logic                  mem_done_o,
  output RegBus                 mem_rdata_o,
  output logic                  stallreq_o,
  input  RamDataBus             ram_din_i,
  output RamDataBus             ram_dout_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic                  ram_wr_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [2:0]            num_q, num_d;
  logic [2:0]            cnt_q, cnt_d;
  RegBus                 wbuf_q, wbuf_d;
  RegBus                 rbuf_q, rbuf_d;
  RegBus                 ifData_q, ifData_d;
  RegBus                 memRdata_q, memRdata_d;
  logic                  ifDone_q, ifDone_d;
  logic                  memDone_q, memDone_d;
  logic [ADDR_WIDTH-1:0] curAddr;
  logic [1:0]            rdIdx;

  assign curAddr = base_q + ADDR_WIDTH'(cnt_q);
  // Read data lags its address by one cycle, so byte cnt-1 arrives now.
  assign rdIdx   = 2'(cnt_q - 3'd1);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    wbuf_d     = wbuf_q;
    rbuf_d     = rbuf_q;
    ifData_d   = ifData_q;
    memRdata_d = memRdata_q;
    ifDone_d   = 1'b0;
    memDone_d  = 1'b0;
    ram_a_o    = '0;
    ram_dout_o = '0;
    ram_wr_o   = 1'b0;

    case (state_q)
      IDLE: begin
        // A request still held during its own done pulse must not restart.
        if (!ifDone_q && !memDone_q) begin
          if (mem_req_i) begin
            state_d = mem_we_i ? MEM_WR : MEM_RD;
            base_d  = mem_addr_i;
            num_d   = lenToBytes(mem_len_i);
            wbuf_d  = mem_wdata_i;
            cnt_d   = 3'd0;
            rbuf_d  = '0;
          end else if (if_req_i && !if_cancel_i) begin
            state_d = IF_RD;
            base_d  = if_addr_i;
            num_d   = 3'd4;
            cnt_d   = 3'd0;
            rbuf_d  = '0;
          end
        end
      end

      MEM_WR: begin
        ram_a_o    = curAddr;
        ram_dout_o = wbuf_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_wr_o   = 1'b1;
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == num_q - 3'd1) begin
          state_d   = IDLE;
          memDone_d = 1'b1;
        end
      end

      IF_RD, MEM_RD: begin
        if (cnt_q < num_q) begin
          ram_a_o = curAddr;
        end
        if (cnt_q != 3'd0) begin
          rbuf_d[{rdIdx, 3'b000} +: 8] = ram_din_i;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == num_q) begin
          state_d = IDLE;
          if (state_q == IF_RD) begin
            ifDone_d = 1'b1;
            ifData_d = rbuf_d;
          end else begin
            memDone_d  = 1'b1;
            memRdata_d = rbuf_d;
          end
        end
        if (state_q == IF_RD && if_cancel_i) begin
          state_d  = IDLE;
          ifDone_d = 1'b0;
          ifData_d = ifData_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      wbuf_q     <= '0;
      rbuf_q     <= '0;
      ifData_q   <= '0;
      memRdata_q <= '0;
      ifDone_q   <= 1'b0;
      memDone_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      wbuf_q     <= wbuf_d;
      rbuf_q     <= rbuf_d;
      ifData_q   <= ifData_d;
      memRdata_q <= memRdata_d;
      ifDone_q   <= ifDone_d;
      memDone_q  <= memDone_d;
    end
  end

  assign if_done_o   = ifDone_q;
  assign if_data_o   = ifData_q;
  assign mem_done_o  = memDone_q;
  assign mem_rdata_o = memRdata_q;
  // Gated by reset so every output reads zero while reset is held.
  assign stallreq_o  = mem_req_i & ~memDone_q & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario-driven bench for mem_arbiter with a byte RAM model and
// queues of expected read words and RAM writes.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        ifReq, ifCancel, ifDone;
  logic [31:0] ifAddr, ifData;
  logic        memReq, memWe, memDone, stallreq;
  logic [1:0]  memLen;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [7:0]  ramDin, ramDout;
  logic [31:0] ramA;
  logic        ramWr;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [31:0] expIf[$];
  logic [31:0] expMem[$];
  wr_t         expWr[$];
  logic [7:0]  ramModel [logic [31:0]];
  logic [31:0] sampA;
  logic [7:0]  sampD;
  logic        sampWr;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_cancel_i(ifCancel),
    .if_done_o(ifDone), .if_data_o(ifData),
    .mem_req_i(memReq), .mem_we_i(memWe), .mem_len_i(memLen),
    .mem_addr_i(memAddr), .mem_wdata_i(memWdata),
    .mem_done_o(memDone), .mem_rdata_o(memRdata), .stallreq_o(stallreq),
    .ram_din_i(ramDin), .ram_dout_o(ramDout), .ram_a_o(ramA), .ram_wr_o(ramWr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] readByte(input logic [31:0] a);
    if (ramModel.exists(a)) return ramModel[a];
    return 8'h00;
  endfunction

  // RAM port is sampled mid-cycle so the model never races the DUT edge.
  always @(negedge clk) begin
    sampA  = ramA;
    sampD  = ramDout;
    sampWr = ramWr;
  end

  always @(posedge clk) begin
    if (sampWr) ramModel[sampA] = sampD;
    ramDin <= readByte(sampA);
  end

  task automatic loadRam(input logic [31:0] addr, input logic [31:0] word);
    for (int i = 0; i < 4; i++) ramModel[32'(addr + 32'(i))] = word[8*i +: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    memReq = 1'b1;
    #1;
    assertCount++;
    if ({ramWr, ramA, ramDout} !== 41'h0) begin
      failCount++;
      $display("[TB] FAIL reset_ram: got wr=%b a=%h d=%h, expected all 0", ramWr, ramA, ramDout);
    end
    assertCount++;
    if ({ifDone, memDone, stallreq} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %b, expected 000", {ifDone, memDone, stallreq});
    end
    assertCount++;
    if ({ifData, memRdata} !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL reset_data: got %h/%h, expected 0/0", ifData, memRdata);
    end
    memReq = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_if_fetch();
    logic [31:0] exp;
    loadRam(32'h100, 32'h00000013);
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 32'h100;
    expIf.push_back(32'h00000013);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        assertCount++;
        if (ramA !== 32'(32'h100 + 32'(k - 1)) || ramWr !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL fetch_addr k=%0d: got %h wr=%b, expected %h wr=0", k, ramA, ramWr, 32'h100 + 32'(k - 1));
        end
      end
      assertCount++;
      if (ifDone !== (k == 6)) begin
        failCount++;
        $display("[TB] FAIL fetch_done k=%0d: got %b, expected %b", k, ifDone, (k == 6));
      end
    end
    exp = expIf.pop_front();
    assertCount++;
    if (ifData !== exp) begin
      failCount++;
      $display("[TB] FAIL fetch_data: got %h, expected %h", ifData, exp);
    end
    ifReq = 1'b0;
    @(negedge clk);
    assertCount++;
    if (ifDone !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fetch_pulse: got %b, expected 0", ifDone);
    end
  endtask

  task automatic test_priority();
    int k = 0;
    bit stallBad = 0;
    logic [31:0] exp;
    loadRam(32'h200, 32'h12345678);
    loadRam(32'h300, 32'hDDCCBBAA);
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 32'h300;
    memReq = 1'b1; memWe = 1'b0; memLen = 2'b11; memAddr = 32'h200;
    expMem.push_back(32'h12345678);
    expIf.push_back(32'hDDCCBBAA);
    #1;
    if (stallreq !== 1'b1) stallBad = 1;
    do begin
      @(negedge clk); k++;
      if (memDone !== 1'b1 && (stallreq !== 1'b1 || ifDone === 1'b1)) stallBad = 1;
    end while (memDone !== 1'b1 && k < 20);
    assertCount++;
    if (k != 6) begin
      failCount++;
      $display("[TB] FAIL prio_mem_latency: got %0d, expected 6", k);
    end
    exp = expMem.pop_front();
    assertCount++;
    if (memRdata !== exp) begin
      failCount++;
      $display("[TB] FAIL prio_mem_data: got %h, expected %h", memRdata, exp);
    end
    assertCount++;
    if (stallreq !== 1'b0 || stallBad) begin
      failCount++;
      $display("[TB] FAIL prio_stall: got done-cycle %b, earlier-bad %0d, expected 0/0", stallreq, stallBad);
    end
    memReq = 1'b0;
    @(negedge clk); k++;
    @(negedge clk); k++;
    assertCount++;
    if (ramA !== 32'h300) begin
      failCount++;
      $display("[TB] FAIL prio_if_start: got %h, expected 00000300", ramA);
    end
    do begin
      @(negedge clk); k++;
    end while (ifDone !== 1'b1 && k < 40);
    assertCount++;
    if (k != 13) begin
      failCount++;
      $display("[TB] FAIL prio_if_latency: got %0d, expected 13", k);
    end
    exp = expIf.pop_front();
    assertCount++;
    if (ifData !== exp) begin
      failCount++;
      $display("[TB] FAIL prio_if_data: got %h, expected %h", ifData, exp);
    end
    ifReq = 1'b0;
  endtask

  task automatic test_store(input logic [31:0] addr, input logic [1:0] len,
                            input logic [31:0] wdata, input int nBytes);
    int k = 0;
    int writes = 0;
    wr_t w;
    @(negedge clk);
    memReq = 1'b1; memWe = 1'b1; memLen = len; memAddr = addr; memWdata = wdata;
    for (int i = 0; i < nBytes; i++) expWr.push_back(wr_t'{32'(addr + 32'(i)), wdata[8*i +: 8]});
    do begin
      @(negedge clk); k++;
      if (ramWr === 1'b1) begin
        writes++;
        w = (expWr.size() != 0) ? expWr.pop_front() : wr_t'('0);
        assertCount++;
        if ({ramA, ramDout} !== {w.addr, w.data}) begin
          failCount++;
          $display("[TB] FAIL store_write: got %h/%h, expected %h/%h", ramA, ramDout, w.addr, w.data);
        end
      end
    end while (memDone !== 1'b1 && k < 20);
    memReq = 1'b0; memWe = 1'b0;
    assertCount++;
    if (k != nBytes + 1 || writes != nBytes) begin
      failCount++;
      $display("[TB] FAIL store_timing: got done@%0d writes=%0d, expected done@%0d writes=%0d", k, writes, nBytes + 1, nBytes);
    end
    expWr.delete();
  endtask

  task automatic test_load(input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] expData, input int nBytes);
    int k = 0;
    logic [31:0] exp;
    @(negedge clk);
    memReq = 1'b1; memWe = 1'b0; memLen = len; memAddr = addr;
    expMem.push_back(expData);
    do begin
      @(negedge clk); k++;
    end while (memDone !== 1'b1 && k < 20);
    exp = expMem.pop_front();
    assertCount++;
    if (k != nBytes + 2 || memRdata !== exp) begin
      failCount++;
      $display("[TB] FAIL load: got done@%0d data=%h, expected done@%0d data=%h", k, memRdata, nBytes + 2, exp);
    end
    memReq = 1'b0;
  endtask

  task automatic test_cancel();
    int k = 0;
    bit sawIfDone = 0;
    logic [31:0] exp;
    loadRam(32'h500, 32'h04030201);
    ramModel[32'h600] = 8'h5A;
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 32'h500;
    repeat (2) @(negedge clk);
    assertCount++;
    if (ramA !== 32'h501) begin
      failCount++;
      $display("[TB] FAIL cancel_second_rd: got %h, expected 00000501", ramA);
    end
    ifCancel = 1'b1;
    memReq = 1'b1; memWe = 1'b0; memLen = 2'b00; memAddr = 32'h600;
    expMem.push_back(32'h0000005A);
    @(negedge clk);
    assertCount++;
    if (ramA !== 32'h0 || ifDone !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL cancel_idle: got a=%h done=%b, expected 0/0", ramA, ifDone);
    end
    ifCancel = 1'b0; ifReq = 1'b0;
    do begin
      @(negedge clk); k++;
      if (ifDone === 1'b1) sawIfDone = 1;
    end while (memDone !== 1'b1 && k < 20);
    exp = expMem.pop_front();
    assertCount++;
    if (k != 3 || memRdata !== exp) begin
      failCount++;
      $display("[TB] FAIL cancel_mem: got done@%0d data=%h, expected done@3 data=%h", k, memRdata, exp);
    end
    memReq = 1'b0;
    @(negedge clk);
    if (ifDone === 1'b1) sawIfDone = 1;
    assertCount++;
    if (sawIfDone || ifData !== 32'hDDCCBBAA) begin
      failCount++;
      $display("[TB] FAIL cancel_if: got done-seen=%0d data=%h, expected 0/ddccbbaa", sawIfDone, ifData);
    end
  endtask

  task automatic test_cancel_idle();
    int k = 0;
    logic [31:0] exp;
    loadRam(32'h700, 32'h8899AABB);
    @(negedge clk);
    ifReq = 1'b1; ifAddr = 32'h700; ifCancel = 1'b1;
    expIf.push_back(32'h8899AABB);
    @(negedge clk);
    assertCount++;
    if (ramA !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL cancel_blocks_grant: got %h, expected 00000000", ramA);
    end
    ifCancel = 1'b0;
    do begin
      @(negedge clk); k++;
    end while (ifDone !== 1'b1 && k < 20);
    exp = expIf.pop_front();
    assertCount++;
    if (k != 6 || ifData !== exp) begin
      failCount++;
      $display("[TB] FAIL cancel_then_fetch: got done@%0d data=%h, expected done@6 data=%h", k, ifData, exp);
    end
    ifReq = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    @(negedge clk);
    memReq = 1'b1; memWe = 1'b1; memLen = 2'b11; memAddr = 32'h80; memWdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    assertCount++;
    if (ramWr !== 1'b1 || ramA !== 32'h81 || ramDout !== 8'hF0) begin
      failCount++;
      $display("[TB] FAIL midstore_before: got wr=%b a=%h d=%h, expected 1/00000081/f0", ramWr, ramA, ramDout);
    end
    #1 rst = 1'b1;
    #1;
    assertCount++;
    if ({ramWr, ramA, ramDout, stallreq, memDone, ifDone} !== 44'h0 || {ifData, memRdata} !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL midstore_reset: got wr=%b a=%h d=%h stall=%b data=%h/%h, expected all 0", ramWr, ramA, ramDout, stallreq, ifData, memRdata);
    end
    @(negedge clk);
    rst = 1'b0;
    memReq = 1'b0;
    test_store(32'h80, 2'b11, 32'hCAFEF00D, 4);
  endtask

  initial begin
    rst = 1'b1; ifReq = 1'b0; ifAddr = '0; ifCancel = 1'b0;
    memReq = 1'b0; memWe = 1'b0; memLen = 2'b00; memAddr = '0; memWdata = '0;
    test_reset();
    test_if_fetch();
    test_priority();
    test_store(32'h1F, 2'b00, 32'hDEADBEEF, 1);
    loadRam(32'h40, 32'h88991234);
    test_load(32'h40, 2'b01, 32'h00001234, 2);
    test_store(32'hFFFFFFFE, 2'b11, 32'h11223344, 4);
    test_load(32'hFFFFFFFE, 2'b10, 32'h11223344, 4);
    test_cancel();
    test_cancel_idle();
    test_reset_mid_store();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
